// File: rtl/bt_cmd_pkg.sv
// Shared constants for the Bluetooth command link: character set, command codes,
// default clocking, and the receiver FSM encoding.
package bt_cmd_pkg;

  localparam int unsigned DEF_CLK_FREQ = 32'd50000000;
  localparam int unsigned DEF_BAUD     = 32'd9600;

  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [7:0] CH_2 = 8'h32;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_B = 8'h42;

  typedef enum logic [2:0] {
    CMD_STOP = 3'd0,
    CMD_SPD1 = 3'd1,
    CMD_SPD2 = 3'd2,
    CMD_W    = 3'd3,
    CMD_S    = 3'd4,
    CMD_A    = 3'd5,
    CMD_D    = 3'd6,
    CMD_B    = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } decode_t;

  function automatic decode_t decode_char(input logic [7:0] ch);
    decode_t d;
    d.hit  = 1'b1;
    d.code = CMD_STOP;
    case (ch)
      CH_0:    d.code = CMD_STOP;
      CH_1:    d.code = CMD_SPD1;
      CH_2:    d.code = CMD_SPD2;
      CH_W:    d.code = CMD_W;
      CH_S:    d.code = CMD_S;
      CH_A:    d.code = CMD_A;
      CH_D:    d.code = CMD_D;
      CH_B:    d.code = CMD_B;
      default: d.hit  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bt_cmd_rx_if.sv
// Serial input and decoded-command outputs of the car-side receiver.
interface bt_cmd_rx_if;
  logic       Rx;
  logic [2:0] c_s;
  logic       cmd_valid;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  logic       unknown_cmd;

  modport master (
    output Rx,
    input  c_s, cmd_valid, rx_byte, byte_valid, frame_err, unknown_cmd
  );

  modport slave (
    input  Rx,
    output c_s, cmd_valid, rx_byte, byte_valid, frame_err, unknown_cmd
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 LSB-first UART receiver: input synchronizer, mid-bit sampling FSM and bit timer.
// Produces the framed byte with a valid strobe, or a framing-error strobe.
module uart_rx_core
  import bt_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32'd16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned      TW         = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]    HALF_M1    = TW'(CLKS_PER_BIT / 32'd2 - 32'd1);
  localparam logic [TW-1:0]    FULL_M1    = TW'(CLKS_PER_BIT - 32'd1);
  localparam logic [TW-1:0]    TIMER_ONE  = TW'(32'd1);

  logic            r_sync1;
  logic            r_sync2;
  logic            w_rxs;
  rx_state_e       r_state;
  rx_state_e       w_next;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_index;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_byte_valid;
  logic            r_frame_err;

  logic            w_tick_half;
  logic            w_tick_full;
  logic            w_timer_clr;
  logic            w_idx_clr;
  logic            w_shift_en;
  logic            w_done_ok;
  logic            w_done_err;

  assign w_rxs       = r_sync2;
  assign w_tick_half = (r_timer == HALF_M1);
  assign w_tick_full = (r_timer == FULL_M1);

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) w_next = ST_START;
        else        w_next = ST_IDLE;
      end
      ST_START: begin
        if (w_tick_half) w_next = w_rxs ? ST_IDLE : ST_DATA;
        else             w_next = ST_START;
      end
      ST_DATA: begin
        if (w_tick_full && (r_index == 3'd7)) w_next = ST_STOP;
        else                                  w_next = ST_DATA;
      end
      ST_STOP: begin
        if (w_tick_full) w_next = w_rxs ? ST_IDLE : ST_BREAK;
        else             w_next = ST_STOP;
      end
      ST_BREAK: begin
        if (w_rxs) w_next = ST_IDLE;
        else       w_next = ST_BREAK;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The timer restarts at each sample point, so later samples stay mid-bit.
  always_comb begin
    w_timer_clr = 1'b0;
    w_idx_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_clr = 1'b1;
        w_idx_clr   = 1'b1;
      end
      ST_START: begin
        w_timer_clr = w_tick_half;
        w_idx_clr   = 1'b1;
      end
      ST_DATA: begin
        w_timer_clr = w_tick_full;
        w_shift_en  = w_tick_full;
      end
      ST_STOP: begin
        w_timer_clr = w_tick_full;
        w_done_ok   = w_tick_full & w_rxs;
        w_done_err  = w_tick_full & ~w_rxs;
      end
      ST_BREAK: begin
        w_timer_clr = 1'b1;
      end
      default: begin
        w_timer_clr = 1'b1;
        w_idx_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer      <= '0;
      r_index      <= 3'd0;
      r_shift      <= 8'h00;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_timer <= w_timer_clr ? '0 : (r_timer + TIMER_ONE);
      if (w_idx_clr) begin
        r_index <= 3'd0;
      end else if (w_shift_en) begin
        r_index <= r_index + 3'd1;
      end
      if (w_shift_en) begin
        r_shift[r_index] <= w_rxs;
      end
      if (w_done_ok) begin
        r_byte <= r_shift;
      end
      r_byte_valid <= w_done_ok;
      r_frame_err  <= w_done_err;
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/bt_cmd_rx.sv
// Car-side Bluetooth command receiver: UART core plus command-character decode
// and the held command register c_s.
module bt_cmd_rx
  import bt_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic        inclk,
  input  logic        rst,
  bt_cmd_rx_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic [7:0] w_core_byte;
  logic       w_core_valid;
  logic       w_core_ferr;
  decode_t    w_dec;

  logic [2:0] r_c_s;
  logic       r_cmd_valid;
  logic [7:0] r_rx_byte;
  logic       r_byte_valid;
  logic       r_frame_err;
  logic       r_unknown_cmd;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .i_clk        (inclk),
    .i_rst        (rst),
    .i_rx         (bus.Rx),
    .o_byte       (w_core_byte),
    .o_byte_valid (w_core_valid),
    .o_frame_err  (w_core_ferr)
  );

  assign w_dec = decode_char(w_core_byte);

  // All strobes and c_s are re-registered together so they stay cycle-aligned.
  always_ff @(posedge inclk) begin
    if (rst) begin
      r_c_s         <= CMD_STOP;
      r_cmd_valid   <= 1'b0;
      r_rx_byte     <= 8'h00;
      r_byte_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_unknown_cmd <= 1'b0;
    end else begin
      r_byte_valid  <= w_core_valid;
      r_cmd_valid   <= w_core_valid & w_dec.hit;
      r_unknown_cmd <= w_core_valid & ~w_dec.hit;
      r_frame_err   <= w_core_ferr;
      if (w_core_valid) begin
        r_rx_byte <= w_core_byte;
      end
      if (w_core_valid && w_dec.hit) begin
        r_c_s <= w_dec.code;
      end
    end
  end

  assign bus.c_s         = r_c_s;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.rx_byte     = r_rx_byte;
  assign bus.byte_valid  = r_byte_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.unknown_cmd = r_unknown_cmd;

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed bench for bt_cmd_rx: a table of framed characters with expected decode
// results, plus hand-written sequences for break, glitch, back-to-back and reset.
module tb_bt_cmd_rx;

  localparam int unsigned CLK_FREQ = 160;
  localparam int unsigned BAUD     = 10;
  localparam int          CPB      = 16;

  logic clk;
  logic rst;
  bt_cmd_rx_if bus();

  bt_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .inclk (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int cnt_bv = 0, cnt_cmd = 0, cnt_unk = 0, cnt_fe = 0;
  int cnt_multi = 0, cnt_misalign = 0;
  int last_bv_cyc = 0;
  logic [2:0] last_cs = 3'd0, prev_cs = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.byte_valid) begin
      cnt_bv      <= cnt_bv + 1;
      last_bv_cyc <= cyc;
    end
    if (bus.cmd_valid) begin
      cnt_cmd <= cnt_cmd + 1;
      prev_cs <= last_cs;
      last_cs <= bus.c_s;
    end
    if (bus.unknown_cmd) cnt_unk <= cnt_unk + 1;
    if (bus.frame_err) cnt_fe <= cnt_fe + 1;
    if ((int'(bus.cmd_valid) + int'(bus.unknown_cmd) + int'(bus.frame_err)) > 1)
      cnt_multi <= cnt_multi + 1;
    if ((bus.cmd_valid && !bus.byte_valid) || (bus.unknown_cmd && !bus.byte_valid) ||
        (bus.frame_err && bus.byte_valid))
      cnt_misalign <= cnt_misalign + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int s_bv, s_cmd, s_unk, s_fe;
  int start_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_bv = cnt_bv; s_cmd = cnt_cmd; s_unk = cnt_unk; s_fe = cnt_fe;
  endtask

  task automatic chk_deltas(input string name, input int bv, input int cmd, input int unk, input int fe);
    chk({name, ".byte_valid"}, cnt_bv - s_bv, bv);
    chk({name, ".cmd_valid"}, cnt_cmd - s_cmd, cmd);
    chk({name, ".unknown_cmd"}, cnt_unk - s_unk, unk);
    chk({name, ".frame_err"}, cnt_fe - s_fe, fe);
  endtask

  task automatic drive_bit(input logic v, input int cycles);
    bus.Rx = v;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop_v, CPB);
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       stop_v;
    logic [2:0] exp_cs;
    logic [7:0] exp_byte;
    int         exp_bv;
    int         exp_cmd;
    int         exp_unk;
    int         exp_fe;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int lat;
    tbl[0]  = '{8'h57, 1'b1, 3'd3, 8'h57, 1, 1, 0, 0};
    tbl[1]  = '{8'h42, 1'b1, 3'd7, 8'h42, 1, 1, 0, 0};
    tbl[2]  = '{8'h61, 1'b1, 3'd7, 8'h61, 1, 0, 1, 0};
    tbl[3]  = '{8'h42, 1'b1, 3'd7, 8'h42, 1, 1, 0, 0};
    tbl[4]  = '{8'h30, 1'b1, 3'd0, 8'h30, 1, 1, 0, 0};
    tbl[5]  = '{8'h31, 1'b1, 3'd1, 8'h31, 1, 1, 0, 0};
    tbl[6]  = '{8'h53, 1'b1, 3'd4, 8'h53, 1, 1, 0, 0};
    tbl[7]  = '{8'h41, 1'b1, 3'd5, 8'h41, 1, 1, 0, 0};
    tbl[8]  = '{8'h44, 1'b1, 3'd6, 8'h44, 1, 1, 0, 0};
    tbl[9]  = '{8'h32, 1'b1, 3'd2, 8'h32, 1, 1, 0, 0};
    tbl[10] = '{8'h64, 1'b1, 3'd2, 8'h64, 1, 0, 1, 0};
    tbl[11] = '{8'h57, 1'b1, 3'd3, 8'h57, 1, 1, 0, 0};
    tbl[12] = '{8'h31, 1'b0, 3'd3, 8'h57, 0, 0, 0, 1};
    tbl[13] = '{8'h00, 1'b1, 3'd3, 8'h00, 1, 0, 1, 0};

    bus.Rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;

    // Reset state and a quiet idle line.
    snap();
    #1;
    chk("reset.c_s", int'(bus.c_s), 0);
    chk("reset.rx_byte", int'(bus.rx_byte), 0);
    @(posedge clk);
    drive_bit(1'b1, 20 * CPB);
    chk_deltas("idle", 0, 0, 0, 0);

    for (int v = 0; v < 14; v++) begin
      snap();
      send_frame(tbl[v].ch, tbl[v].stop_v);
      drive_bit(1'b1, 2 * CPB);
      chk($sformatf("vec%0d.c_s", v), int'(bus.c_s), int'(tbl[v].exp_cs));
      chk($sformatf("vec%0d.rx_byte", v), int'(bus.rx_byte), int'(tbl[v].exp_byte));
      chk_deltas($sformatf("vec%0d", v), tbl[v].exp_bv, tbl[v].exp_cmd, tbl[v].exp_unk, tbl[v].exp_fe);
      if (tbl[v].exp_cmd == 1)
        chk($sformatf("vec%0d.c_s_at_pulse", v), int'(last_cs), int'(tbl[v].exp_cs));
      if (v == 0) begin
        lat = last_bv_cyc - start_cyc;
        chk("latency_in_window", int'(lat >= (19 * CPB) / 2 && lat <= (19 * CPB) / 2 + 10), 1);
      end
    end

    // Stop bit held low, line kept low three more bit times, then a clean '2'.
    snap();
    send_frame(8'h31, 1'b0);
    drive_bit(1'b0, 3 * CPB);
    chk("break.c_s_held", int'(bus.c_s), 3);
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h32, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    chk_deltas("break", 1, 1, 0, 1);
    chk("break.c_s", int'(bus.c_s), 2);

    // Short low glitch on an idle line must be rejected.
    snap();
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 12 * CPB);
    chk_deltas("glitch", 0, 0, 0, 0);
    chk("glitch.c_s", int'(bus.c_s), 2);

    // Back-to-back 'S' then 'D' with no idle gap.
    snap();
    send_frame(8'h53, 1'b1);
    send_frame(8'h44, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    chk_deltas("b2b", 2, 2, 0, 0);
    chk("b2b.first_c_s", int'(prev_cs), 4);
    chk("b2b.second_c_s", int'(last_cs), 6);
    chk("b2b.c_s", int'(bus.c_s), 6);

    // Reset during the data bits of an 'A' frame, then a full 'A'.
    snap();
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB / 2);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 12 * CPB);
    chk_deltas("midrst", 0, 0, 0, 0);
    chk("midrst.c_s", int'(bus.c_s), 0);
    chk("midrst.rx_byte", int'(bus.rx_byte), 0);
    snap();
    send_frame(8'h41, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    chk_deltas("after_rst", 1, 1, 0, 0);
    chk("after_rst.c_s", int'(bus.c_s), 5);

    chk("one_result_per_frame", cnt_multi, 0);
    chk("strobe_alignment", cnt_misalign, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- UART receiver, 8N1, LSB first, for the Bluetooth link. It is the far-end counterpart of the command-character transmitter.
- Decodes the eight command characters '0' '1' '2' 'W' 'S' 'A' 'D' 'B' back into the 3-bit car command code c_s.
- Sits on the car-side controller between the Bluetooth module's TX pin and the motor/mode logic.
- Also exposes the raw byte and error strobes.

Parameters:
- CLK_FREQ, 50000000, inclk frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), inclk cycles per bit. Integer division, truncated. Must be at least 16.

Ports:
- inclk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- Rx, in, 1, asynchronous serial input; idle high.
- c_s, out, 3, last valid decoded command; held until the next valid command.
- cmd_valid, out, 1, one-cycle pulse when c_s is updated.
- rx_byte, out, 8, last correctly framed byte, whether or not it is a command.
- byte_valid, out, 1, one-cycle pulse when rx_byte is updated.
- frame_err, out, 1, one-cycle pulse when the stop bit is sampled low.
- unknown_cmd, out, 1, one-cycle pulse when a framed byte is not in the command table.

Behaviour:
- Reset: one clock with rst=1 sets state=IDLE and clears all counters. Outputs after reset: c_s=3'b000, rx_byte=0, and all pulses 0. The synchronizer flops are set to 1. Reset mid-frame abandons the frame with no pulses.
- Rx passes through a 2-flop synchronizer. All logic uses the synchronized signal rxs.
- A bit-timer counts 0..CLKS_PER_BIT-1. A bit index counts 0..7.
- FSM states:
  - IDLE: on rxs=0, go to START with timer cleared.
  - START: when timer reaches CLKS_PER_BIT/2-1, sample rxs. If rxs=0, go to DATA and clear timer and index. If rxs=1, treat it as a glitch and return to IDLE with no pulse.
  - DATA: when timer reaches CLKS_PER_BIT-1, shift rxs into bit[index], so the first data bit lands in bit0. Clear timer. After index 7, go to STOP.
  - STOP: when timer reaches CLKS_PER_BIT-1, sample rxs.
    - rxs=1: go to IDLE. In the same cycle, load rx_byte, pulse byte_valid, and decode (see below).
    - rxs=0: pulse frame_err and go to BREAK. rx_byte and c_s are unchanged.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line being read as repeated frames.
- Decode table (byte to c_s):
  - 0x30 '0' → 000
  - 0x31 '1' → 001
  - 0x32 '2' → 010
  - 0x57 'W' → 011
  - 0x53 'S' → 100
  - 0x41 'A' → 101
  - 0x44 'D' → 110
  - 0x42 'B' → 111
- For a byte in the table: c_s updates and cmd_valid pulses in the same cycle as byte_valid.
- For any other byte: unknown_cmd pulses and c_s holds. Lowercase letters are not commands.
- Timing: pulses fire 9.5 bit times plus 2 synchronizer cycles after the start edge. At most one of cmd_valid, unknown_cmd, or frame_err fires per frame.
- Back-to-back frames: a start edge seen in IDLE on the cycle after STOP completes is accepted, so zero idle time between frames is tolerated.
- The transmitter re-sends a character only when its command changes. A repeated identical byte still pulses cmd_valid, with c_s unchanged in value.
- Tolerance: mid-bit sampling tolerates ±4% baud mismatch. The transmitter's 9600.6 Hz rate is well inside this.

Decomposition:
- Shared package bt_cmd_pkg holds:
  - the character constants CH_0, CH_1, CH_2, CH_W, CH_S, CH_A, CH_D, CH_B (8-bit);
  - the 3-bit command codes CMD_STOP..CMD_B;
  - the default CLK_FREQ and BAUD.
  The transmitter also uses this package.
- One natural sub-module, uart_rx_core: synchronizer, FSM and timer, producing rx_byte, byte_valid and frame_err.
- The top level adds the decode table and the c_s register.

Test Plan:
- Reset then idle line: after rst, c_s=000 and no pulses for 20 bit times.
- Send 0x57 'W' at 9600 baud: rx_byte=0x57, byte_valid=1, cmd_valid=1, and c_s=011 from the pulse cycle onward. Then send 0x42 'B': c_s=111.
- Send 0x61 'a': byte_valid=1, unknown_cmd=1, and c_s holds its previous value of 111.
- Hold the stop bit low on a 0x31 frame: frame_err=1 and c_s unchanged. Keep Rx low 3 bit times then release and send 0x32: c_s=010 with exactly one cmd_valid.
- Apply a 0.3-bit low glitch on an idle line: no pulses, state returns to IDLE. Then back-to-back 'S' and 'D' with no idle gap: c_s goes to 100 and then to 110, with two cmd_valid pulses.
- Assert rst during DATA of an 'A' frame: no pulses, c_s=000. The next full 'A' frame gives c_s=101.
